// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 constants, types and round helper functions
//               (S-box, Rcon, SubWord, RotWord, ShiftRows, MixColumns).
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } aes_fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Rcon for rounds 1..10, stored at index round-1
    localparam aes_byte_t RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic aes_byte_t rcon_of(input logic [3:0] round);
        aes_byte_t r;
        r = 8'h00;
        if (round >= 4'd1 && round <= LAST_ROUND) begin
            r = RCON[round - 4'd1];
        end
        return r;
    endfunction

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic aes_word_t sub_word(input aes_word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        end
        return o;
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4 of the same row
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t o;
        aes_byte_t  a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_step
// Description : Combinational AES-128 key expansion step: derives round key
//               r from round key r-1 using RotWord, SubWord and Rcon[r].
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] round_key,
    input  logic [3:0]   round,
    output logic [127:0] next_key
);

    aes_word_t w0, w1, w2, w3;
    aes_word_t temp;
    aes_word_t n0, n1, n2, n3;

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    assign temp = sub_word(rot_word(w3)) ^ {rcon_of(round), 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule : aes_key_step
`default_nettype wire

// File: rtl/aes_128_core.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_core
// Description : Iterative AES-128 encryption core, one round per clock with
//               on-the-fly key expansion. start -> done latency is 11 cycles.
//               Optional macro AES_128_CORE_BUSY_EN adds a busy output.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_128_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic [127:0] ciphertext,
    output logic         done
`ifdef AES_128_CORE_BUSY_EN
    ,
    output logic         busy
`endif
);

    aes_fsm_t   fsm, fsm_next;
    aes_state_t state;
    aes_state_t round_key;
    logic [3:0] round;

    logic       load;
    logic       step;
    logic       finish;

    aes_state_t next_key;
    aes_state_t shifted;
    aes_state_t round_out;

    aes_key_step u_key_step (
        .round_key (round_key),
        .round     (round),
        .next_key  (next_key)
    );

    // Round datapath: final round skips MixColumns
    always_comb begin
        shifted   = shift_rows(sub_bytes(state));
        round_out = ((round == LAST_ROUND) ? shifted : mix_columns(shifted)) ^ next_key;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // FSM next-state and datapath control
    always_comb begin
        fsm_next = fsm;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (fsm)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    fsm_next = RUN;
                end
            end
            RUN: begin
                if (round == LAST_ROUND) begin
                    finish   = 1'b1;
                    fsm_next = IDLE;
                end else begin
                    step     = 1'b1;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // State, round key, counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= '0;
            round_key  <= '0;
            round      <= 4'd0;
            ciphertext <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state     <= plaintext ^ key;
                round_key <= key;
                round     <= 4'd1;
            end
            if (step) begin
                state     <= round_out;
                round_key <= next_key;
                round     <= round + 4'd1;
            end
            if (finish) begin
                ciphertext <= round_out;
                round      <= 4'd0;
                done       <= 1'b1;
            end
        end
    end

`ifdef AES_128_CORE_BUSY_EN
    assign busy = (fsm == RUN);
`endif

endmodule : aes_128_core
`default_nettype wire

// File: tb/tb_aes_128_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_128_core
// Description : Directed FIPS-197 vector bench for aes_128_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_128_core;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic [127:0] ciphertext;
    logic         done;
`ifdef AES_128_CORE_BUSY_EN
    logic         busy;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_128_core dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .plaintext  (plaintext),
        .ciphertext (ciphertext),
        .done       (done)
`ifdef AES_128_CORE_BUSY_EN
        ,
        .busy       (busy)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] k, input logic [127:0] p);
        start     = 1'b1;
        key       = k;
        plaintext = p;
        tick();
        start     = 1'b0;
    endtask

    // Ticks until done (bounded); lat = edges after the call, -1 on timeout
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
`ifdef AES_128_CORE_BUSY_EN
            if (busy) busy_cnt++;
`endif
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    task automatic check_busy(input string tag, input logic exp_busy, input int cnt, input int exp_cnt);
`ifdef AES_128_CORE_BUSY_EN
        check({tag, "_busy"}, {127'd0, busy}, {127'd0, exp_busy});
        if (exp_cnt >= 0) check({tag, "_busy_cnt"}, 128'(cnt), 128'(exp_cnt));
`else
        if (tag.len() < 0) $display("%0d %0d %0d", exp_busy, cnt, exp_cnt);
`endif
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;

        rst       = 1'b1;
        start     = 1'b0;
        key       = '0;
        plaintext = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ct", ciphertext, 128'd0);
        check("reset_done", {127'd0, done}, 128'd0);
        check_busy("reset", 1'b0, 0, -1);

        // FIPS-197 C.1
        accept(C1_KEY, C1_PT);
        wait_done(lat, bcnt);
        check("c1_latency", 128'(lat), 128'd10);
        check("c1_ct", ciphertext, C1_CT);
        check_busy("c1_done_cycle", 1'b0, bcnt, 10);
        tick();
        check("c1_done_pulse", {127'd0, done}, 128'd0);
        check("c1_ct_hold", ciphertext, C1_CT);

        // FIPS-197 Appendix B
        accept(B_KEY, B_PT);
        wait_done(lat, bcnt);
        check("b_latency", 128'(lat), 128'd10);
        check("b_ct", ciphertext, B_CT);
        tick();

        // All-zero vector, inputs change one cycle after accept
        accept(128'd0, 128'd0);
        key       = C1_KEY;
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        wait_done(lat, bcnt);
        check("zero_latency", 128'(lat), 128'd10);
        check("zero_ct", ciphertext, Z_CT);
        tick();

        // start during RUN is ignored; then back-to-back start in done cycle
        accept(B_KEY, B_PT);
        count_done(4, dcnt);
        start     = 1'b1;
        key       = C1_KEY;
        plaintext = C1_PT;
        tick();
        start     = 1'b0;
        if (done) dcnt++;
        check("ovl_early_done", 128'(dcnt), 128'd0);
        wait_done(lat, bcnt);
        check("ovl_latency", 128'(lat), 128'd5);
        check("ovl_ct", ciphertext, B_CT);
        accept(C1_KEY, C1_PT);
        check("b2b_done_pulse", {127'd0, done}, 128'd0);
        check_busy("b2b_accept", 1'b1, 0, -1);
        wait_done(lat, bcnt);
        check("b2b_latency", 128'(lat), 128'd10);
        check("b2b_ct", ciphertext, C1_CT);
        check_busy("b2b_done_cycle", 1'b0, bcnt, 10);
        count_done(15, dcnt);
        check("b2b_single_done", 128'(dcnt), 128'd0);

        // Reset mid-operation aborts the block
        accept(C1_KEY, C1_PT);
        count_done(5, dcnt);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (done) dcnt++;
        check("abort_ct", ciphertext, 128'd0);
        check_busy("abort", 1'b0, 0, -1);
        count_done(15, bcnt);
        check("abort_no_done", 128'(dcnt + bcnt), 128'd0);
        accept(C1_KEY, C1_PT);
        wait_done(lat, bcnt);
        check("restart_latency", 128'(lat), 128'd10);
        check("restart_ct", ciphertext, C1_CT);
        tick();

        // rst and start together: request dropped
        rst       = 1'b1;
        start     = 1'b1;
        key       = B_KEY;
        plaintext = B_PT;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_busy("rst_start", 1'b0, 0, -1);
        count_done(15, dcnt);
        check("rst_start_no_done", 128'(dcnt), 128'd0);
        check("rst_start_ct", ciphertext, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_aes_128_core
`default_nettype wire
